// File: rtl/execute_pipe.sv
// execute_pipe: handshaked execute stage between issue and writeback.
// Single-cycle logic/arithmetic ops; MUL runs an iterative shift-add over
// WIDTH cycles. The response sits in an output register that holds steady
// under writeback backpressure.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           request handshake
//   opcode, operand1/2, in_tag  request payload, captured at accept
//   out_valid/out_ready         response handshake
//   result, overflow, error     response payload
//   out_tag                     tag of the request that produced the response
module execute_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 8,
    parameter int unsigned TAGW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             error,
    output logic [TAGW-1:0]  out_tag
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [OPW-1:0] OP_CLR  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_NAND = OPW'(7);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(9);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [TAGW-1:0]   mtag_q, mtag_d;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              error_q, error_d;
    logic [TAGW-1:0]   out_tag_q, out_tag_d;

    logic [WIDTH-1:0]  alu_result_c;
    logic              alu_ovf_c;
    logic              alu_err_c;
    logic [WIDTH:0]    sum_c;
    logic [WIDTH:0]    diff_c;
    logic [PW-1:0]     shl_c;
    logic [SHW-1:0]    shamt_c;
    logic [PW-1:0]     prod_next_c;
    logic              out_free_c;
    logic              accept_c;

    // Request side may only hand over while idle and the output register can take a result.
    assign out_free_c = !out_valid_q || out_ready;
    assign in_ready   = !reset && (state_q == S_IDLE) && out_free_c;
    assign accept_c   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign error     = error_q;
    assign out_tag   = out_tag_q;

    // Single-cycle operations; the extra top bit of sum/diff is carry/borrow.
    always_comb begin
        alu_result_c = '0;
        alu_ovf_c    = 1'b0;
        alu_err_c    = 1'b0;
        shamt_c      = operand2[SHW-1:0];
        sum_c        = {1'b0, operand1} + {1'b0, operand2};
        diff_c       = {1'b0, operand1} - {1'b0, operand2};
        shl_c        = {{WIDTH{1'b0}}, operand1} << shamt_c;
        case (opcode)
            OP_CLR:  alu_result_c = '0;
            OP_ADD: begin
                alu_result_c = sum_c[WIDTH-1:0];
                alu_ovf_c    = sum_c[WIDTH];
            end
            OP_SUB: begin
                alu_result_c = diff_c[WIDTH-1:0];
                alu_ovf_c    = diff_c[WIDTH];
            end
            OP_MUL:  alu_result_c = '0;
            OP_XOR:  alu_result_c = operand1 ^ operand2;
            OP_AND:  alu_result_c = operand1 & operand2;
            OP_OR:   alu_result_c = operand1 | operand2;
            OP_NAND: alu_result_c = ~(operand1 & operand2);
            OP_SHL: begin
                alu_result_c = shl_c[WIDTH-1:0];
                alu_ovf_c    = |shl_c[PW-1:WIDTH];
            end
            OP_SHR:  alu_result_c = operand1 >> shamt_c;
            default: alu_err_c = 1'b1;
        endcase
    end

    // Partial product including the multiplier bit consumed this step.
    assign prod_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Sequencer and output register next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mtag_d      = mtag_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        overflow_d  = overflow_q;
        error_d     = error_q;
        out_tag_d   = out_tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (opcode == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, operand1};
                        mplier_d = operand2;
                        mtag_d   = in_tag;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_result_c;
                        overflow_d  = alu_ovf_c;
                        error_d     = alu_err_c;
                        out_tag_d   = in_tag;
                    end
                end
            end
            S_MUL: begin
                acc_d    = prod_next_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    cnt_d = '0;
                    if (out_free_c) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        result_d    = prod_next_c[WIDTH-1:0];
                        overflow_d  = |prod_next_c[PW-1:WIDTH];
                        error_d     = 1'b0;
                        out_tag_d   = mtag_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Finished product parked in acc_q until the output register frees.
                if (out_free_c) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = acc_q[WIDTH-1:0];
                    overflow_d  = |acc_q[PW-1:WIDTH];
                    error_d     = 1'b0;
                    out_tag_d   = mtag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mtag_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mtag_q      <= mtag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            error_q     <= error_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule
